// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: funct3 encodings, FSM state type,
// wait counter width and the alignment rule for loads and stores.
package mem_pkg;

    localparam int CNT_W = 4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Unknown funct3 codes are reported as misaligned so they never touch memory.
    function automatic logic access_misaligned(input logic [2:0] f3,
                                               input logic       is_store,
                                               input logic [1:0] lo);
        logic mis;
        mis = 1'b1;
        if (is_store) begin
            case (f3)
                F3_SB:   mis = 1'b0;
                F3_SH:   mis = lo[0];
                F3_SW:   mis = |lo;
                default: mis = 1'b1;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LBU: mis = 1'b0;
                F3_LH, F3_LHU: mis = lo[0];
                F3_LW:         mis = |lo;
                default:       mis = 1'b1;
            endcase
        end
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_dmem_array.sv
// Word-organised data RAM with per-byte write enables and a combinational read port.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: the array has no reset; clearing it would turn the RAM into flops.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/mem_stage_dmem.sv
// MEM stage: wait-state FSM, store lane steering, load extension and the
// MEM/WB pipeline register in front of write-back.
module mem_stage_dmem
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_out_exmem,
    input  logic [31:0] store_data_exmem,
    input  logic [4:0]  rd_exmem,
    input  logic [2:0]  funct3_exmem,
    input  logic        reg_write_exmem,
    input  logic        mem_read_exmem,
    input  logic        mem_write_exmem,
    input  logic        mem_to_reg_exmem,
    output logic        mem_stall,
    output logic [31:0] read_data_memwb,
    output logic [31:0] alu_out_memwb,
    output logic [4:0]  rd_memwb,
    output logic        reg_write_memwb,
    output logic        mem_to_reg_memwb,
    output logic        misalign_err_memwb
);

    localparam int               IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] WS    = CNT_W'(WAIT_STATES);
    localparam logic             HAS_WAIT = (WAIT_STATES > 0);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic        req;
    logic        is_load;
    logic        misaligned;
    logic        stall_raw;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;
    logic [31:0] load_val;

    assign req        = mem_read_exmem | mem_write_exmem;
    assign is_load    = mem_read_exmem & ~mem_write_exmem;
    // A simultaneous read and write request is rejected like a misaligned access.
    assign misaligned = req & ((mem_read_exmem & mem_write_exmem) |
                        access_misaligned(funct3_exmem, mem_write_exmem, alu_out_exmem[1:0]));

    assign stall_raw = (state == IDLE) ? (req & HAS_WAIT) : (req & (cnt < WS));
    assign mem_stall = rst & stall_raw;
    assign mem_we    = rst & req & ~mem_stall & mem_write_exmem & ~misaligned;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req && HAS_WAIT) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            WAIT: begin
                if (!req || cnt >= WS) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Sub-word stores replicate their data so the enabled lanes pick it up.
    always_comb begin
        mem_be    = 4'b0000;
        mem_wdata = store_data_exmem;
        case (funct3_exmem)
            F3_SB: begin
                mem_be    = 4'b0001 << alu_out_exmem[1:0];
                mem_wdata = {4{store_data_exmem[7:0]}};
            end
            F3_SH: begin
                mem_be    = alu_out_exmem[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{store_data_exmem[15:0]}};
            end
            F3_SW:   mem_be = 4'b1111;
            default: mem_be = 4'b0000;
        endcase
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_dmem (
        .clk   (clk),
        .we    (mem_we),
        .be    (mem_be),
        .idx   (alu_out_exmem[IDX_W+1:2]),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_comb begin
        load_byte = mem_rdata[7:0];
        case (alu_out_exmem[1:0])
            2'd0:    load_byte = mem_rdata[7:0];
            2'd1:    load_byte = mem_rdata[15:8];
            2'd2:    load_byte = mem_rdata[23:16];
            default: load_byte = mem_rdata[31:24];
        endcase
        load_half = alu_out_exmem[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_exmem)
            F3_LB:   load_ext = {{24{load_byte[7]}}, load_byte};
            F3_LH:   load_ext = {{16{load_half[15]}}, load_half};
            F3_LW:   load_ext = mem_rdata;
            F3_LBU:  load_ext = {24'h0, load_byte};
            F3_LHU:  load_ext = {16'h0, load_half};
            default: load_ext = '0;
        endcase
        load_val = (is_load && !misaligned) ? load_ext : '0;
    end

    // While stalled the register loads a bubble; data fields keep their last value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data_memwb    <= '0;
            alu_out_memwb      <= '0;
            rd_memwb           <= '0;
            reg_write_memwb    <= 1'b0;
            mem_to_reg_memwb   <= 1'b0;
            misalign_err_memwb <= 1'b0;
        end else if (mem_stall) begin
            reg_write_memwb    <= 1'b0;
            mem_to_reg_memwb   <= 1'b0;
            misalign_err_memwb <= 1'b0;
        end else begin
            read_data_memwb    <= load_val;
            alu_out_memwb      <= alu_out_exmem;
            rd_memwb           <= rd_exmem;
            reg_write_memwb    <= reg_write_exmem & ~misaligned;
            mem_to_reg_memwb   <= mem_to_reg_exmem;
            misalign_err_memwb <= misaligned;
        end
    end

endmodule

// File: tb/tb_mem_stage_dmem.sv
// Directed plus randomized bench for mem_stage_dmem against a byte-level memory model.
module tb_mem_stage_dmem;

    localparam int WS        = 2;
    localparam int DEPTH     = 256;
    localparam int MEM_BYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_out_exmem, store_data_exmem;
    logic [4:0]  rd_exmem;
    logic [2:0]  funct3_exmem;
    logic        reg_write_exmem, mem_read_exmem, mem_write_exmem, mem_to_reg_exmem;

    logic        mem_stall, reg_write_memwb, mem_to_reg_memwb, misalign_err_memwb;
    logic [31:0] read_data_memwb, alu_out_memwb;
    logic [4:0]  rd_memwb;

    logic        z_stall, z_reg_write, z_mem_to_reg, z_misalign;
    logic [31:0] z_read_data, z_alu_out;
    logic [4:0]  z_rd;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model [int];
    logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    always #5 clk = ~clk;

    mem_stage_dmem #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst),
        .alu_out_exmem(alu_out_exmem), .store_data_exmem(store_data_exmem),
        .rd_exmem(rd_exmem), .funct3_exmem(funct3_exmem),
        .reg_write_exmem(reg_write_exmem), .mem_read_exmem(mem_read_exmem),
        .mem_write_exmem(mem_write_exmem), .mem_to_reg_exmem(mem_to_reg_exmem),
        .mem_stall(mem_stall), .read_data_memwb(read_data_memwb),
        .alu_out_memwb(alu_out_memwb), .rd_memwb(rd_memwb),
        .reg_write_memwb(reg_write_memwb), .mem_to_reg_memwb(mem_to_reg_memwb),
        .misalign_err_memwb(misalign_err_memwb)
    );

    mem_stage_dmem #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst),
        .alu_out_exmem(alu_out_exmem), .store_data_exmem(store_data_exmem),
        .rd_exmem(rd_exmem), .funct3_exmem(funct3_exmem),
        .reg_write_exmem(reg_write_exmem), .mem_read_exmem(mem_read_exmem),
        .mem_write_exmem(mem_write_exmem), .mem_to_reg_exmem(mem_to_reg_exmem),
        .mem_stall(z_stall), .read_data_memwb(z_read_data),
        .alu_out_memwb(z_alu_out), .rd_memwb(z_rd),
        .reg_write_memwb(z_reg_write), .mem_to_reg_memwb(z_mem_to_reg),
        .misalign_err_memwb(z_misalign)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rdn, input logic rw, input logic m2r);
        mem_read_exmem   = rd_en;
        mem_write_exmem  = wr_en;
        funct3_exmem     = f3;
        alu_out_exmem    = addr;
        store_data_exmem = data;
        rd_exmem         = rdn;
        reg_write_exmem  = rw;
        mem_to_reg_exmem = m2r;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"},    32'(mem_stall), 32'h0);
        check({tag, "_rdata"},    read_data_memwb, 32'h0);
        check({tag, "_alu"},      alu_out_memwb, 32'h0);
        check({tag, "_rd"},       32'(rd_memwb), 32'h0);
        check({tag, "_rw"},       32'(reg_write_memwb), 32'h0);
        check({tag, "_m2r"},      32'(mem_to_reg_memwb), 32'h0);
        check({tag, "_mis"},      32'(misalign_err_memwb), 32'h0);
    endtask

    // One instruction through the WAIT_STATES=2 instance; expectations come from
    // the byte-addressed model and the size/alignment rules.
    task automatic run_op(input string tag, input logic rd_en, input logic wr_en,
                          input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] rdn, input logic rw, input logic m2r);
        bit          req, valid, mis;
        int          sz, stalls, idx;
        longint      v;
        logic [31:0] exp_rd;
        req   = rd_en || wr_en;
        sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
        valid = wr_en ? (f3 inside {3'b000, 3'b001, 3'b010})
                      : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        mis = 1'b0;
        if (req) begin
            if (!valid || (rd_en && wr_en)) mis = 1'b1;
            else if ((addr % 32'(sz)) != 0) mis = 1'b1;
        end
        exp_rd = 32'h0;
        if (rd_en && !wr_en && !mis) begin
            v = 0;
            for (int k = 0; k < sz; k++) begin
                idx = int'((addr + 32'(k)) % 32'(MEM_BYTES));
                v = v | (longint'(model[idx]) << (8 * k));
            end
            if (!f3[2] && sz < 4 && v[8*sz-1]) v = v - (longint'(1) << (8 * sz));
            exp_rd = v[31:0];
        end

        drive(rd_en, wr_en, f3, addr, data, rdn, rw, m2r);
        stalls = 0;
        @(negedge clk);
        while (mem_stall === 1'b1 && stalls < 40) begin
            stalls++;
            @(posedge clk); #1;
            if (stalls == 1) check({tag, "_bubble_rw"}, 32'(reg_write_memwb), 32'h0);
            @(negedge clk);
        end
        check({tag, "_stall_cycles"}, 32'(stalls), req ? 32'(WS) : 32'h0);
        @(posedge clk); #1;
        check({tag, "_alu"},   alu_out_memwb, addr);
        check({tag, "_rd"},    32'(rd_memwb), 32'(rdn));
        check({tag, "_rw"},    32'(reg_write_memwb), 32'(rw && !mis));
        check({tag, "_m2r"},   32'(mem_to_reg_memwb), 32'(m2r));
        check({tag, "_mis"},   32'(misalign_err_memwb), 32'(mis));
        check({tag, "_rdata"}, read_data_memwb, exp_rd);

        if (wr_en && !mis) begin
            for (int k = 0; k < sz; k++)
                model[int'((addr + 32'(k)) % 32'(MEM_BYTES))] = data[8*k +: 8];
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Reset, with a pending request that must not raise the stall.
        rst = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd1, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("reset_stall0", 32'(z_stall), 32'h0);
        check("reset_rw0",    32'(z_reg_write), 32'h0);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // ALU pass-through
        run_op("alu", 1'b0, 1'b0, 3'b000, 32'h12345678, 32'h0, 5'd7, 1'b1, 1'b0);
        check("alu_const_out", alu_out_memwb, 32'h12345678);
        check("alu_const_rd",  32'(rd_memwb), 32'd7);

        // SW then LW, back to back
        run_op("sw40", 1'b0, 1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0);
        run_op("lw40", 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd5, 1'b1, 1'b1);
        check("lw40_const", read_data_memwb, 32'hDEADBEEF);

        // Sub-word accesses
        run_op("sw40b", 1'b0, 1'b1, 3'b010, 32'h40, 32'h8000FF7F, 5'd0, 1'b0, 1'b0);
        run_op("lb40",  1'b1, 1'b0, 3'b000, 32'h40, 32'h0, 5'd1, 1'b1, 1'b1);
        check("lb40_const", read_data_memwb, 32'h0000007F);
        run_op("lb41",  1'b1, 1'b0, 3'b000, 32'h41, 32'h0, 5'd2, 1'b1, 1'b1);
        check("lb41_const", read_data_memwb, 32'hFFFFFFFF);
        run_op("lbu41", 1'b1, 1'b0, 3'b100, 32'h41, 32'h0, 5'd3, 1'b1, 1'b1);
        check("lbu41_const", read_data_memwb, 32'h000000FF);
        run_op("lh42",  1'b1, 1'b0, 3'b001, 32'h42, 32'h0, 5'd4, 1'b1, 1'b1);
        check("lh42_const", read_data_memwb, 32'hFFFF8000);
        run_op("sb43",  1'b0, 1'b1, 3'b000, 32'h43, 32'h000000AA, 5'd0, 1'b0, 1'b0);
        run_op("lw40c", 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd6, 1'b1, 1'b1);
        check("sb43_const", read_data_memwb, 32'hAA00FF7F);

        // Misaligned and malformed requests
        run_op("lw42mis", 1'b1, 1'b0, 3'b010, 32'h42, 32'h0, 5'd8, 1'b1, 1'b1);
        check("lw42_mis_const", 32'(misalign_err_memwb), 32'h1);
        run_op("sh41mis", 1'b0, 1'b1, 3'b001, 32'h41, 32'h00001234, 5'd0, 1'b0, 1'b0);
        run_op("lw40d",   1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd9, 1'b1, 1'b1);
        check("sh41_nowrite", read_data_memwb, 32'hAA00FF7F);
        run_op("both_hi", 1'b1, 1'b1, 3'b010, 32'h44, 32'h0, 5'd10, 1'b1, 1'b1);
        run_op("bad_f3",  1'b1, 1'b0, 3'b011, 32'h40, 32'h0, 5'd11, 1'b1, 1'b1);
        run_op("lhu42",   1'b1, 1'b0, 3'b101, 32'h42, 32'h0, 5'd12, 1'b1, 1'b1);

        // Reset during the wait of a store abandons it
        run_op("sw80", 1'b0, 1'b1, 3'b010, 32'h80, 32'h01020304, 5'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 3'b010, 32'h80, 32'hCAFEF00D, 5'd13, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        check_all_zero("midreset");
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        run_op("lw80", 1'b1, 1'b0, 3'b010, 32'h80, 32'h0, 5'd14, 1'b1, 1'b1);
        check("lw80_const", read_data_memwb, 32'h01020304);

        // Address wrap
        run_op("sw400", 1'b0, 1'b1, 3'b010, 32'h400, 32'h00000055, 5'd0, 1'b0, 1'b0);
        run_op("lw000", 1'b1, 1'b0, 3'b010, 32'h000, 32'h0, 5'd15, 1'b1, 1'b1);
        check("wrap_const", read_data_memwb, 32'h00000055);

        // Randomized traffic over a pre-initialised window
        for (int w = 0; w < 16; w++)
            run_op($sformatf("init%0d", w), 1'b0, 1'b1, 3'b010, 32'h100 + 32'(4 * w),
                   $urandom, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            a    = 32'h100 + 32'($urandom_range(0, 63));
            if (kind < 2)
                run_op($sformatf("rnd%0d_alu", i), 1'b0, 1'b0, 3'(kind), $urandom, $urandom,
                       5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else if (kind < 6)
                run_op($sformatf("rnd%0d_ld", i), 1'b1, 1'b0, ld_f3[$urandom_range(0, 4)], a, 32'h0,
                       5'($urandom_range(0, 31)), 1'b1, 1'b1);
            else
                run_op($sformatf("rnd%0d_st", i), 1'b0, 1'b1, 3'($urandom_range(0, 2)), a, $urandom,
                       5'($urandom_range(0, 31)), 1'b0, 1'b0);
        end

        // Zero-wait instance: wrap and no stall
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 3'b010, 32'h400, 32'h00000011, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("ws0_sw_stall", 32'(z_stall), 32'h0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 3'b010, 32'h000, 32'h0, 5'd3, 1'b1, 1'b1);
        @(negedge clk);
        check("ws0_lw_stall", 32'(z_stall), 32'h0);
        @(posedge clk); #1;
        check("ws0_lw_rdata", z_read_data, 32'h00000011);
        check("ws0_lw_rw",    32'(z_reg_write), 32'h1);
        check("ws0_lw_rd",    32'(z_rd), 32'd3);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage_dmem.md
# mem_stage_dmem

MEM stage of the 5-stage RISC-V pipeline. Consumes the EX/MEM pipeline-register outputs and services loads and stores against an internal byte-enabled data memory with a configurable number of wait states. Asserts a stall while an access is in flight. Drives the MEM/WB pipeline register that feeds write-back.

## Interface
Parameters:
- DEPTH_WORDS, 256 — data memory depth in 32-bit words; power of two.
- WAIT_STATES, 2 — stall cycles per memory access; legal range 0..15.

Ports:
- clk  input  1  — single clock, rising edge.
- rst  input  1  — asynchronous, active-low reset.
- alu_out_exmem  input  32  — effective address for loads and stores; result for ALU ops.
- store_data_exmem  input  32  — store source data.
- rd_exmem  input  5  — destination register.
- funct3_exmem  input  3  — access size and sign.
- reg_write_exmem, mem_read_exmem, mem_write_exmem, mem_to_reg_exmem  input  1 each  — control bits.
- mem_stall  output  1  — stall request to the hazard unit; EX/MEM and earlier stages hold while it is high.
- read_data_memwb  output  32  — extended load data.
- alu_out_memwb  output  32  — registered copy of alu_out_exmem.
- rd_memwb  output  5  — registered copy of rd_exmem.
- reg_write_memwb, mem_to_reg_memwb  output  1 each  — registered control bits.
- misalign_err_memwb  output  1  — one-entry flag marking a misaligned access.

## Operation
- A request (req) is present when mem_read_exmem or mem_write_exmem is high. If both are high, the access is treated as a store and misalign_err_memwb is set for that entry.
- FSM states:
  - IDLE → WAIT when req is present and WAIT_STATES > 0. cnt loads 1.
  - WAIT increments cnt each edge. When cnt == WAIT_STATES, the access commits on that edge and the FSM returns to IDLE.
- mem_stall = req && (IDLE ? WAIT_STATES > 0 : cnt < WAIT_STATES). mem_stall is forced to 0 while rst is low.
- Non-memory instructions pass through with no stall.
- The MEM/WB register captures on every edge where mem_stall is low. While mem_stall is high, MEM/WB loads a bubble: reg_write_memwb=0, mem_to_reg_memwb=0, misalign_err_memwb=0, other fields hold.
- Word index = alu_out_exmem[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo the memory size.
- funct3 encodings:
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
  - Any other funct3 on a request is treated as misaligned.
- Byte lane = addr[1:0]. Halfword lane = addr[1].
- Loads are sign-extended (LB/LH) or zero-extended (LBU/LHU).
- Byte enables:
  - SB: one lane; the store data byte is replicated across lanes.
  - SH: lanes {1,0} or {3,2}.
  - SW: all four lanes.
- Misaligned cases are halfword access with addr[0]=1, and word access with addr[1:0]≠0. For a misaligned access:
  - no memory write is performed;
  - read_data_memwb=0;
  - reg_write_memwb=0;
  - misalign_err_memwb=1 for that single entry.
- reg_write_memwb and mem_to_reg_memwb otherwise copy their EX/MEM inputs.

## Timing
- Reset: FSM=IDLE, cnt=0, and every MEM/WB output is 0. Memory contents are not reset. Reset asserted mid-access abandons the access; no write occurs.
- ALU op: MEM/WB updates on the next edge (latency 1).
- Memory op: mem_stall is high for exactly WAIT_STATES cycles. The write, or the read data capture, happens on edge WAIT_STATES+1 after the request first appears. With WAIT_STATES=0, latency is 1 and there is no stall.
- Back-to-back memory ops: the second request's stall begins in the cycle immediately after the first commits. There are no idle gaps.
- A store followed by a load to the same word returns the newly stored data.

## Structure
- Package mem_pkg holds:
  - funct3 load/store constants;
  - the state enum typedef (IDLE, WAIT);
  - the cnt width localparam (4 bits).
- Sub-module dmem_array: DEPTH_WORDS×32 RAM with 4-bit byte-enable write and asynchronous read. The FSM, extension logic and MEM/WB register live in mem_stage_dmem.

## Test plan
- ALU pass-through: alu_out=0x12345678, rd=7, reg_write=1 → next edge alu_out_memwb=0x12345678, rd_memwb=7, mem_stall never high.
- SW then LW, WAIT_STATES=2: SW 0xDEADBEEF to 0x40 → mem_stall high for 2 cycles. LW 0x40 → read_data_memwb=0xDEADBEEF on edge 3, with bubbles (reg_write_memwb=0) during the stall.
- Sub-word accesses, with word 0x40 = 0x8000FF7F:
  - LB 0x40 → 0x0000007F;
  - LB 0x41 → 0xFFFFFFFF;
  - LBU 0x41 → 0x000000FF;
  - LH 0x42 → 0xFFFF8000;
  - SB 0xAA to 0x43 → word becomes 0xAA00FF7F.
- Misaligned access: LW 0x42 → misalign_err_memwb=1, reg_write_memwb=0, read_data_memwb=0. SH to 0x41 leaves memory unchanged.
- Reset mid-access: assert rst low during the WAIT of SW 0x80 → outputs 0, FSM IDLE, word at 0x80 unchanged.
- Wrap and zero wait, DEPTH_WORDS=256, WAIT_STATES=0: SW 0x11 to 0x400 → LW 0x000 returns 0x00000011, no stall.
